// File: rtl/conv_1x1_mac_engine.sv
// conv_1x1_mac_engine: streaming 1x1 convolution multiply-accumulate engine.
// Stores CHANNEL_NUM_IN*CHANNEL_NUM_OUT weights, gathers CHANNEL_NUM_IN channel
// words per pixel, runs one MAC per cycle and emits CHANNEL_NUM_OUT saturated
// Q-format results per kept pixel. Optional stride-2 decimation drops pixels
// on odd rows/columns.
// Optional feature macro: CONV1X1_MAC_RELU_EN clamps negative results to zero.
// Handshake: a pixel word transfers on a rising edge where valid_in && ready_in;
// a weight transfers on a rising edge where valid_weight_in is high while the
// engine is loading weights; valid_out is a one-cycle strobe per result with
// no downstream backpressure.
module conv_1x1_mac_engine #(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAC_BITS       = 8,
    parameter int CHANNEL_NUM_IN  = 4,
    parameter int CHANNEL_NUM_OUT = 2,
    parameter int IMAGE_WIDTH     = 4,
    parameter int IMAGE_HEIGHT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  stride2,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  weights_ready,
    output logic                  frame_done,
    output logic [1:0]            dbg_state_o
);
    localparam int DW  = DATA_WIDTH;
    localparam int NW  = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
    localparam int KW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int CW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int AW  = 2 * DW + $clog2(CHANNEL_NUM_IN) + 1;

    localparam logic [1:0] S_WLOAD   = 2'd0;
    localparam logic [1:0] S_GATHER  = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [KW-1:0]        k_q, k_d;        // weight index (also load counter)
    logic [IW-1:0]        i_q, i_d;        // MAC input-channel index
    logic [IW-1:0]        ich_q, ich_d;    // gather channel index
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 stride_q, stride_d;
    logic                 flush_q, flush_d;      // MACs done, final result draining
    logic                 is_last_q, is_last_d;  // pixel in compute ends the frame
    logic                 out_pend_q, out_pend_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [DW-1:0]        pxl_out_q, pxl_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 wrdy_q, wrdy_d;
    logic                 frame_done_q, frame_done_d;

    logic signed [DW-1:0] w_q   [NW];
    logic signed [DW-1:0] pix_q [CHANNEL_NUM_IN];

    logic signed [DW-1:0]   pix_sel, w_sel;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_base, acc_next, shifted;
    logic [DW-1:0]          result;
    logic                   pix_last, drop;

    // Datapath: one signed product per cycle, accumulate, shift, saturate.
    always_comb begin
        pix_sel  = pix_q[i_q];
        w_sel    = w_q[k_q];
        prod     = (2*DW)'(pix_sel) * (2*DW)'(w_sel);
        acc_base = (i_q == '0) ? '0 : acc_q;
        acc_next = acc_base + AW'(prod);
        shifted  = acc_q >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            result = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            result = OUT_MIN;
        end else begin
            result = shifted[DW-1:0];
        end
`ifdef CONV1X1_MAC_RELU_EN
        if (result[DW-1]) begin
            result = '0;
        end
`endif
    end

    // Control FSM and position tracking: next-state computation.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        i_d          = i_q;
        ich_d        = ich_q;
        col_d        = col_q;
        row_d        = row_q;
        stride_d     = stride_q;
        flush_d      = 1'b0;
        is_last_d    = is_last_q;
        out_pend_d   = 1'b0;
        acc_d        = acc_q;
        pxl_out_d    = pxl_out_q;
        valid_out_d  = 1'b0;
        wrdy_d       = wrdy_q;
        frame_done_d = 1'b0;
        pix_last     = (col_q == CW'(IMAGE_WIDTH - 1)) && (row_q == RW'(IMAGE_HEIGHT - 1));
        drop         = stride_q && (row_q[0] || col_q[0]);

        // The accumulator is complete one cycle after the last MAC of an output.
        if (out_pend_q) begin
            pxl_out_d   = result;
            valid_out_d = 1'b1;
        end

        case (state_q)
            S_WLOAD: begin
                if (valid_weight_in) begin
                    if (k_q == KW'(NW - 1)) begin
                        k_d     = '0;
                        wrdy_d  = 1'b1;
                        state_d = S_GATHER;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_GATHER: begin
                if (valid_in) begin
                    if (ich_q == '0 && col_q == '0 && row_q == '0) begin
                        stride_d = stride2;
                    end
                    if (ich_q == IW'(CHANNEL_NUM_IN - 1)) begin
                        ich_d = '0;
                        if (col_q == CW'(IMAGE_WIDTH - 1)) begin
                            col_d = '0;
                            row_d = (row_q == RW'(IMAGE_HEIGHT - 1)) ? '0 : row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        if (drop) begin
                            frame_done_d = pix_last;
                        end else begin
                            state_d   = S_COMPUTE;
                            is_last_d = pix_last;
                        end
                    end else begin
                        ich_d = ich_q + IW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (flush_q) begin
                    // Leaves with the final valid_out so ready_in rises alongside it.
                    state_d      = S_GATHER;
                    frame_done_d = is_last_q;
                end else begin
                    acc_d = acc_next;
                    if (i_q == IW'(CHANNEL_NUM_IN - 1)) begin
                        i_d        = '0;
                        out_pend_d = 1'b1;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                    if (k_q == KW'(NW - 1)) begin
                        k_d     = '0;
                        flush_d = 1'b1;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = S_WLOAD;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WLOAD;
            k_q          <= '0;
            i_q          <= '0;
            ich_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            stride_q     <= 1'b0;
            flush_q      <= 1'b0;
            is_last_q    <= 1'b0;
            out_pend_q   <= 1'b0;
            acc_q        <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            wrdy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            i_q          <= i_d;
            ich_q        <= ich_d;
            col_q        <= col_d;
            row_q        <= row_d;
            stride_q     <= stride_d;
            flush_q      <= flush_d;
            is_last_q    <= is_last_d;
            out_pend_q   <= out_pend_d;
            acc_q        <= acc_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            wrdy_q       <= wrdy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Weight and pixel storage; contents are only trusted once the FSM has loaded them.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_WLOAD && valid_weight_in) begin
            w_q[k_q] <= weight_in;
        end
        if (!reset && state_q == S_GATHER && valid_in) begin
            pix_q[ich_q] <= pxl_in;
        end
    end

    assign ready_in      = (state_q == S_GATHER);
    assign pxl_out       = pxl_out_q;
    assign valid_out     = valid_out_q;
    assign weights_ready = wrdy_q;
    assign frame_done    = frame_done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_conv_1x1_mac_engine.sv
// tb_conv_1x1_mac_engine: table-driven single-pixel vectors plus frame-level
// sequences (stride-2 decimation, continuous valid_in, reset mid-compute).
module tb_conv_1x1_mac_engine;
  localparam int DW = 16;
  localparam int CI = 4;
  localparam int CO = 2;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NW = CI * CO;

  typedef struct packed {
    logic [NW-1:0][DW-1:0] w;
    logic [CI-1:0][DW-1:0] px;
    logic [CO-1:0][DW-1:0] exp_v;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic          ready_in;
  logic          valid_weight_in;
  logic [DW-1:0] weight_in;
  logic          stride2;
  logic [DW-1:0] pxl_out;
  logic          valid_out;
  logic          weights_ready;
  logic          frame_done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  conv_1x1_mac_engine #(
    .DATA_WIDTH(DW), .FRAC_BITS(8), .CHANNEL_NUM_IN(CI), .CHANNEL_NUM_OUT(CO),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .ready_in(ready_in), .valid_weight_in(valid_weight_in), .weight_in(weight_in),
    .stride2(stride2), .pxl_out(pxl_out), .valid_out(valid_out),
    .weights_ready(weights_ready), .frame_done(frame_done), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  longint        exp_t_q[$];
  int            vo_cnt = 0;
  int            fd_cnt = 0;
  longint        fd_time = 0;
  int            held = 0;
  logic [DW-1:0] mon_e;
  longint        mon_t;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [DW-1:0] relu16(input logic [DW-1:0] v);
`ifdef CONV1X1_MAC_RELU_EN
    if (v[DW-1]) return '0;
`endif
    return v;
  endfunction

  // Golden model: full-precision sum, floor shift, saturate, optional clamp.
  function automatic logic [DW-1:0] model(input logic [CI-1:0][DW-1:0] px,
                                          input logic [NW-1:0][DW-1:0] w, input int o);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < CI; i++)
      acc += longint'($signed(px[i])) * longint'($signed(w[o*CI+i]));
    r = acc >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return relu16(r[DW-1:0]);
  endfunction

  // Output monitor: compares value and arrival time of every strobe.
  always @(negedge clk) begin
    if (valid_out) begin
      vo_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_out", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        chk("pxl_out", 64'(pxl_out), 64'(mon_e));
        chk("out_time", 64'($time), 64'(mon_t));
      end
    end
    if (frame_done) begin
      fd_cnt++;
      fd_time = $time;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    valid_weight_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
  endtask

  task automatic load_weights(input logic [NW-1:0][DW-1:0] w);
    for (int j = 0; j < NW; j++) begin
      valid_weight_in = 1'b1;
      weight_in = w[j];
      if (j == 0) chk("ready_in_low_in_wload", 64'(ready_in), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    valid_weight_in = 1'b0;
    chk("weights_ready_after_load", 64'(weights_ready), 64'd1);
  endtask

  task automatic send_word(input logic [DW-1:0] v, output longint ta);
    int guard;
    guard = 0;
    valid_in = 1'b1;
    pxl_in = v;
    while (!ready_in && guard < 300) begin
      held++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) chk("ready_in_timeout", 64'd1, 64'd0);
    @(posedge clk);
    ta = $time;
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [CI-1:0][DW-1:0] px, input logic [NW-1:0][DW-1:0] w,
                            input bit keep, input bit use_model,
                            input logic [CO-1:0][DW-1:0] texp, output longint ta);
    for (int i = 0; i < CI; i++) send_word(px[i], ta);
    if (keep) begin
      for (int o = 0; o < CO; o++) begin
        exp_q.push_back(use_model ? model(px, w, o) : texp[o]);
        exp_t_q.push_back(ta + 10 * (1 + (o + 1) * CI) + 5);
      end
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  vec_t                  vecs[6];
  logic [NW-1:0][DW-1:0] wr;
  logic [CI-1:0][DW-1:0] pxr;
  longint                ta;
  int                    bad;
  int                    n;

  initial begin
    reset = 1'b1;
    valid_in = 1'b0;
    pxl_in = '0;
    valid_weight_in = 1'b0;
    weight_in = '0;
    stride2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pxl_out", 64'(pxl_out), 64'd0);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_weights_ready", 64'(weights_ready), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // Table: basic, saturate high, saturate low, weight order, mixed signs, floor shift.
    for (int j = 0; j < NW; j++) begin
      vecs[0].w[j] = 16'h0100;
      vecs[1].w[j] = 16'h7F00;
      vecs[2].w[j] = 16'h7F00;
      vecs[3].w[j] = (j < CI) ? 16'h0100 : 16'h0200;
      vecs[5].w[j] = 16'hFFFF;
    end
    for (int i = 0; i < CI; i++) begin
      vecs[0].px[i] = 16'(16'h0100 * (i + 1));
      vecs[1].px[i] = 16'h7F00;
      vecs[2].px[i] = 16'h8100;
      vecs[3].px[i] = 16'h0100;
      vecs[5].px[i] = (i == 0) ? 16'h0001 : 16'h0000;
    end
    vecs[4].w[0] = 16'h0080; vecs[4].w[1] = 16'hFF00; vecs[4].w[2] = 16'h0200; vecs[4].w[3] = 16'h0000;
    vecs[4].w[4] = 16'h0100; vecs[4].w[5] = 16'h0100; vecs[4].w[6] = 16'hFF80; vecs[4].w[7] = 16'h0040;
    vecs[4].px[0] = 16'h0300; vecs[4].px[1] = 16'h0100; vecs[4].px[2] = 16'hFE00; vecs[4].px[3] = 16'h1000;
    vecs[0].exp_v[0] = 16'h0A00;         vecs[0].exp_v[1] = 16'h0A00;
    vecs[1].exp_v[0] = 16'h7FFF;         vecs[1].exp_v[1] = 16'h7FFF;
    vecs[2].exp_v[0] = relu16(16'h8000); vecs[2].exp_v[1] = relu16(16'h8000);
    vecs[3].exp_v[0] = 16'h0400;         vecs[3].exp_v[1] = 16'h0800;
    vecs[4].exp_v[0] = relu16(16'hFC80); vecs[4].exp_v[1] = 16'h0900;
    vecs[5].exp_v[0] = relu16(16'hFFFF); vecs[5].exp_v[1] = relu16(16'hFFFF);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_weights(vecs[v].w);
      send_pixel(vecs[v].px, vecs[v].w, 1'b1, 1'b0, vecs[v].exp_v, ta);
      valid_in = 1'b0;
      wait_drain();
    end

    // Reset during compute: pending results discarded, weights must reload.
    do_reset();
    for (int j = 0; j < NW; j++) wr[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
    load_weights(wr);
    for (int i = 0; i < CI; i++) pxr[i] = 16'($urandom_range(0, 1023));
    send_pixel(pxr, wr, 1'b1, 1'b1, '0, ta);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_compute_before_reset", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      valid_in = 1'b1;
      pxl_in = 16'($urandom_range(0, 65535));
      if (valid_out || ready_in || weights_ready) bad++;
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk("quiet_after_mid_reset", 64'(bad), 64'd0);
    for (int j = 0; j < NW; j++) wr[j] = 16'(16'h0040 * (j + 1));
    load_weights(wr);
    send_pixel(pxr, wr, 1'b1, 1'b1, '0, ta);
    valid_in = 1'b0;
    wait_drain();

    // Stride-2 frame: only even row/col pixels produce results.
    do_reset();
    for (int j = 0; j < NW; j++) wr[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
    load_weights(wr);
    vo_cnt = 0;
    fd_cnt = 0;
    stride2 = 1'b1;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        for (int i = 0; i < CI; i++) pxr[i] = 16'($urandom_range(0, 65535));
        send_pixel(pxr, wr, !((r % 2 == 1) || (c % 2 == 1)), 1'b1, '0, ta);
        stride2 = 1'b0;
      end
    end
    valid_in = 1'b0;
    wait_drain();
    chk("stride_out_count", 64'(vo_cnt), 64'd8);
    chk("stride_frame_done_count", 64'(fd_cnt), 64'd1);
    chk("stride_frame_done_time", 64'(fd_time), 64'(ta + 5));

    // Continuous valid_in across a full frame: held off during compute, nothing lost.
    vo_cnt = 0;
    fd_cnt = 0;
    held = 0;
    n = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        for (int i = 0; i < CI; i++) begin
          pxr[i] = 16'(16'h0040 * n);
          n++;
        end
        send_pixel(pxr, wr, 1'b1, 1'b1, '0, ta);
      end
    end
    valid_in = 1'b0;
    wait_drain();
    chk("bp_out_count", 64'(vo_cnt), 64'(IW * IH * CO));
    chk("bp_frame_done_count", 64'(fd_cnt), 64'd1);
    chk("bp_frame_done_time", 64'(fd_time), 64'(ta + 10 * (1 + CO * CI) + 5));
    chk("bp_held_off", 64'(held > 0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
